// File: rtl/alu_pkg.sv
// Shared ALU datapath types: serial subtractor state encoding and default width.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage : alu_pkg

// File: rtl/full_subtractor_1bit.sv
// 1-bit full subtractor cell: d = x - y - bin, bout set when the bit underflows.
module full_subtractor_1bit (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference and borrow for one bit position
    always_comb begin
        d    = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
    end

endmodule : full_subtractor_1bit

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, one bit per clock, LSB first.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; operands are captured on the accepting edge
// RUN   | one bit per edge through the full-subtractor cell (busy = 1)
// DONE  | single-cycle done pulse; diff/borrow_out/zero are valid
module serial_subtractor
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero
);

    localparam int CNT_W = $clog2(WIDTH);

    sub_state_t       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] rs_q, rs_d;
    logic             borrow_q, borrow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_out_q, borrow_out_d;
    logic             zero_q, zero_d;

    logic             bit_d;
    logic             bit_bout;

    full_subtractor_1bit u_fsub (
        .x    (sa_q[0]),
        .y    (sb_q[0]),
        .bin  (borrow_q),
        .d    (bit_d),
        .bout (bit_bout)
    );

    // Next-state, datapath shift and result capture
    always_comb begin
        state_d      = state_q;
        sa_d         = sa_q;
        sb_d         = sb_q;
        rs_d         = rs_q;
        borrow_d     = borrow_q;
        cnt_d        = cnt_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;
        zero_d       = zero_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d     = a;
                    sb_d     = b;
                    rs_d     = '0;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                sa_d     = sa_q >> 1;
                sb_d     = sb_q >> 1;
                rs_d     = {bit_d, rs_q[WIDTH-1:1]};
                borrow_d = bit_bout;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    // Last bit: counter parks at zero so it never passes WIDTH-1
                    cnt_d        = '0;
                    diff_d       = rs_d;
                    borrow_out_d = bit_bout;
                    zero_d       = (rs_d == '0);
                    state_d      = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sa_q         <= '0;
            sb_q         <= '0;
            rs_q         <= '0;
            borrow_q     <= 1'b0;
            cnt_q        <= '0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            zero_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sa_q         <= sa_d;
            sb_q         <= sb_d;
            rs_q         <= rs_d;
            borrow_q     <= borrow_d;
            cnt_q        <= cnt_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
            zero_q       <= zero_d;
        end
    end

    // Handshake outputs decode straight from the state register
    always_comb begin
        busy       = (state_q == RUN);
        done       = (state_q == DONE);
        diff       = diff_q;
        borrow_out = borrow_out_q;
        zero       = zero_q;
    end

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at WIDTH = 8.
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             zero;

    int n_vec;
    int n_err;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .zero       (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Start one operation at a negedge, follow it to completion and check everything.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input bit check_timing);
        int busy_cycles;
        int lat;
        bit seen;
        logic [7:0] exp_d;
        exp_d = av - bv;
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_cycles = 0;
        lat  = 0;
        seen = 1'b0;
        if (busy) busy_cycles++;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (done) seen = 1'b1;
            else if (busy) busy_cycles++;
        end
        check("done_seen", {31'd0, seen}, 32'd1);
        if (check_timing) begin
            check("done_latency", lat, 32'd8);
            check("busy_cycles", busy_cycles, 32'd8);
            check("busy_at_done", {31'd0, busy}, 32'd0);
        end
        check("diff", {24'd0, diff}, {24'd0, exp_d});
        check("borrow_out", {31'd0, borrow_out}, {31'd0, (av < bv)});
        check("zero", {31'd0, zero}, {31'd0, (exp_d == 8'd0)});
        @(negedge clk);
        if (check_timing) check("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    initial begin
        int ndone;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;

        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_diff", {24'd0, diff}, 32'd0);
        check("rst_borrow", {31'd0, borrow_out}, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic, underflow, zero and extremes
        run_op(8'h05, 8'h03, 1'b1);
        run_op(8'h03, 8'h05, 1'b1);
        run_op(8'h00, 8'h01, 1'b1);
        check("wrap_ones", {24'd0, diff}, 32'h0000_00FF);
        run_op(8'h00, 8'h00, 1'b1);
        run_op(8'hFF, 8'h01, 1'b1);
        run_op(8'h80, 8'h7F, 1'b1);
        run_op(8'hAA, 8'h55, 1'b1);
        check("aa_55", {24'd0, diff}, 32'h0000_0055);

        // Start held through RUN and DONE, operands changed after capture
        @(negedge clk);
        a     = 8'h20;
        b     = 8'h01;
        start = 1'b1;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) ndone++;
            if (i == 1) begin
                a = 8'h10;
                b = 8'h01;
            end
        end
        start = 1'b0;
        check("prot_one_done", ndone, 32'd1);
        check("prot_diff", {24'd0, diff}, 32'h0000_001F);
        @(negedge clk);
        check("prot_no_restart", {31'd0, busy}, 32'd0);
        check("prot_no_done", {31'd0, done}, 32'd0);
        run_op(8'h10, 8'h01, 1'b1);

        // Reset asynchronously in the middle of RUN
        @(negedge clk);
        a     = 8'h01;
        b     = 8'h02;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_diff", {24'd0, diff}, 32'd0);
        check("mid_rst_borrow", {31'd0, borrow_out}, 32'd0);
        check("mid_rst_zero", {31'd0, zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check("mid_rst_quiet", ndone, 32'd0);
        run_op(8'h09, 8'h04, 1'b1);

        // Random back-to-back operations
        for (int i = 0; i < 500; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            run_op(ra, rb, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_serial_subtractor
